mac_norm_pack_pipe: RTL and testbench
=====================================

Name: mac_norm_pack_pipe

Overview:
Parametrised, pipelined successor to the MAC output normalise/pack stage. It takes a normalised significand with leading 1, the exponent components, sign and Q-format fraction count, and computes the final biased exponent. It handles zero, subnormal, normal and overflow cases, then packs a {sign, exp, man} float. Adds valid/ready flow control, 2-stage pipelining, guard bits, overflow saturation/inf, and sticky exception flags; sits between the MAC accumulator normaliser and the result writeback.

Parameters:
EXP_W, 5, output exponent field width
MAN_W, 10, output mantissa field width (sum carries MAN_W+1 significant bits)
GUARD_W, 2, extra LSBs below the mantissa used for rounding/sticky
MAXE_W, 6, max_exp width (unsigned)
DIFF_W, 5, signed_exp_diff width (two's complement)
Q_W, 5, q_frac width (unsigned)
EXP_OFFSET, 9, constant subtracted in exponent (accumulator bias minus output bias)
SATURATE, 0, 0: overflow -> infinity; 1: overflow -> max finite

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept input
norm_sum  in  MAN_W+1+GUARD_W  significand, leading 1 at MSB (or all zero)
signed_exp_diff  in  DIFF_W  signed normalisation shift
exp_carry  in  1  accumulator carry-out
sign  in  1  result sign
max_exp  in  MAXE_W  unsigned max operand exponent
q_frac  in  Q_W  fractional scaling count
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output
mac_out  out  1+EXP_W+MAN_W  packed result
oflow  out  1  this beat overflowed (qualified by out_valid)
uflow  out  1  this beat was subnormal-inexact or flushed to zero (qualified)
clr_flags  in  1  synchronous clear of sticky flags
oflow_sticky  out  1  OR of all accepted oflow beats since reset/clear
uflow_sticky  out  1  OR of all accepted uflow beats since reset/clear

Behaviour:
- Interface: one clk; reset is asynchronous, active-low (rst_n). All outputs and pipeline valids reset to 0.
- Transfer on valid&ready on each side. Stage S1 registers final_exp/zero/flags; stage S2 registers the packed result.
- Latency 2 cycles with out_ready=1; full throughput of 1 beat/cycle.
- Stall rule: S2 loads when !out_valid | out_ready. S1 advances when S2 loads. in_ready = !s1_valid | s1_advance; no combinational path from in_valid to in_ready.
- Payload held stable while out_valid & !out_ready.
- final_exp = max_exp + sext(signed_exp_diff) + exp_carry - EXP_OFFSET - q_frac. Computed signed at width max(MAXE_W,DIFF_W,Q_W)+3 with no wrap.
- zero: norm_sum == 0 -> {sign, 0...}; oflow=uflow=0.
- normal: 1 <= final_exp <= 2^EXP_W-2 -> exp field = final_exp[EXP_W-1:0]; man = norm_sum bits below the leading 1 (top MAN_W).
- subnormal: final_exp <= 0, s = 1-final_exp. man = (norm_sum[MSB:GUARD_W] >> s)[MAN_W-1:0], exp field 0. For s >= MAN_W+1, result is {sign, 0}.
- uflow=1 when subnormal and any nonzero bit is shifted out or dropped (including the guard bits).
- overflow: final_exp >= 2^EXP_W-1. SATURATE=0 gives {sign, all-1 exp, 0 man}; SATURATE=1 gives {sign, 2^EXP_W-2, all-1 man}. oflow=1.
- Rounding (only with the optional feature) may carry man into exp. A carry to exp 2^EXP_W-1 is treated as overflow. A subnormal rounding up to exp 1 is a legal normal result.
- Sticky flags set on output handshake of a flagged beat. clr_flags wins over a same-cycle set.
- Reset mid-operation discards all in-flight beats; no output appears after reset release without new input.

Optional Feature:
MAC_NORM_RNE_EN
- Defined: round-to-nearest-even. Guard = first dropped bit; sticky = OR of the rest, including subnormal shift-out. Round up if guard & (sticky | lsb). The increment is applied to {exp,man} as one integer.
- Not defined: truncation (legacy behaviour); GUARD_W bits only feed uflow/sticky detection.
- Latency is unchanged either way.

Test Plan:
- Normal: max_exp=30, diff=0, carry=0, q=0, sign=0, norm_sum=13'b1_0000000001_00 -> mac_out=0x5401 two cycles later; flags 0.
- Subnormal: max_exp=9, diff=-1 (5'b11111), carry=0, q=0, norm_sum=13'h1000 -> final_exp=-1, mac_out=0x0100, uflow=0.
- Zero and flush: norm_sum=0, sign=1 -> 0x8000. Then final_exp=-10 with norm_sum=13'h1000 -> 0x0000, uflow=1, uflow_sticky=1 until clr_flags.
- Overflow: max_exp=63, diff=15, carry=1, q=0 -> 0x7C00 and oflow=1 (SATURATE=0); 0x7BFF with SATURATE=1.
- Rounding: final_exp=21, norm_sum=13'b1_1111111111_10 -> 0x5800 with MAC_NORM_RNE_EN, 0x57FF without.
- Backpressure: 8-beat stream with out_ready toggled randomly and deasserted for 5 cycles -> in_ready drops after 2 beats buffered, no loss/duplication, order preserved, payload stable while stalled; rst_n pulse mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/mac_norm_pack_pipe.sv
// Two-stage valid/ready normalise-and-pack stage: MAC significand + exponent parts -> {sign, exp, man}.
// Optional round-to-nearest-even when MAC_NORM_RNE_EN is defined; truncation otherwise.
module mac_norm_pack_pipe #(
  parameter int EXP_W      = 5,
  parameter int MAN_W      = 10,
  parameter int GUARD_W    = 2,
  parameter int MAXE_W     = 6,
  parameter int DIFF_W     = 5,
  parameter int Q_W        = 5,
  parameter int EXP_OFFSET = 9,
  parameter int SATURATE   = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MAN_W+GUARD_W:0]     norm_sum,
  input  logic [DIFF_W-1:0]          signed_exp_diff,
  input  logic                       exp_carry,
  input  logic                       sign,
  input  logic [MAXE_W-1:0]          max_exp,
  input  logic [Q_W-1:0]             q_frac,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       mac_out,
  output logic                       oflow,
  output logic                       uflow,
  input  logic                       clr_flags,
  output logic                       oflow_sticky,
  output logic                       uflow_sticky
);

  localparam int SUM_W  = MAN_W + 1 + GUARD_W;
  localparam int MAG_W  = EXP_W + MAN_W;
  localparam int MX1_W  = (MAXE_W > DIFF_W) ? MAXE_W : DIFF_W;
  localparam int CALC_W = ((MX1_W > Q_W) ? MX1_W : Q_W) + 3;
  localparam int EXT_W  = SUM_W + MAN_W + 2;
  localparam int SH_MAX = MAN_W + 2;
  localparam int SH_W   = $clog2(SH_MAX + 1);

  localparam logic signed [CALC_W-1:0] OFFSET_C = CALC_W'(EXP_OFFSET);
  localparam logic signed [CALC_W-1:0] EXP_TOP  = CALC_W'((1 << EXP_W) - 1);
  localparam logic signed [CALC_W-1:0] ONE_C    = CALC_W'(1);
  localparam logic signed [CALC_W-1:0] SH_MAX_C = CALC_W'(SH_MAX);

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic s2_load;
  logic s1_advance;

  assign s2_load    = !out_valid || out_ready;
  assign s1_advance = s2_load;
  assign in_ready   = !s1_valid || s1_advance;

  // ---------------------------------------------------------------------------
  // Stage 1: biased exponent and classification
  // ---------------------------------------------------------------------------
  logic signed [CALC_W-1:0] final_exp;
  logic                     in_zero;
  logic                     in_ovf;
  logic                     in_sub;

  always_comb begin
    final_exp = CALC_W'(max_exp) + CALC_W'(signed'(signed_exp_diff)) + CALC_W'(exp_carry)
              - OFFSET_C - CALC_W'(q_frac);
    in_zero   = (norm_sum == '0);
    in_ovf    = (final_exp >= EXP_TOP);
    in_sub    = (final_exp < ONE_C);
  end

  logic [SUM_W-1:0]         s1_sum;
  logic signed [CALC_W-1:0] s1_exp;
  logic                     s1_sign;
  logic                     s1_zero;
  logic                     s1_ovf;
  logic                     s1_sub;

  // NOTE: datapath registers are reset as well so every output is 0 out of reset,
  // not just the valids; NOTE: state is assigned with <= so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_exp   <= '0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_ovf   <= 1'b0;
      s1_sub   <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_sum  <= norm_sum;
        s1_exp  <= final_exp;
        s1_sign <= sign;
        s1_zero <= in_zero;
        s1_ovf  <= in_ovf;
        s1_sub  <= in_sub;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: denormalise, round, pack
  // ---------------------------------------------------------------------------
  logic signed [CALC_W-1:0] sub_shift;
  logic [SH_W-1:0]          shamt;
  logic [EXT_W-2:0]         ext;
  logic [MAN_W-1:0]         man_t;
  logic [EXP_W-1:0]         exp_t;
  logic                     guard;
  logic                     sticky;
  logic                     round_up;
  logic [MAG_W:0]           mag;
  logic                     rnd_ovf;
  logic [EXP_W+MAN_W:0]     res;
  logic                     res_oflow;
  logic                     res_uflow;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    shamt     = '0;
    res       = '0;
    res_oflow = 1'b0;
    res_uflow = 1'b0;

    sub_shift = ONE_C - s1_exp;
    if (s1_sub) begin
      if (sub_shift > SH_MAX_C) shamt = SH_W'(SH_MAX);
      else                      shamt = sub_shift[SH_W-1:0];
    end

    // Hidden-bit position is dropped by the cast; below it sit man, guard, then sticky bits.
    ext    = (EXT_W-1)'({s1_sum, {(MAN_W+2){1'b0}}} >> shamt);
    man_t  = ext[EXT_W-2 -: MAN_W];
    guard  = ext[EXT_W-MAN_W-2];
    sticky = |ext[EXT_W-MAN_W-3:0];
    exp_t  = s1_sub ? '0 : s1_exp[EXP_W-1:0];

`ifdef MAC_NORM_RNE_EN
    round_up = guard && (sticky || man_t[0]);
`else
    round_up = 1'b0;
`endif

    // Rounding carries straight from man into exp by treating {exp, man} as one integer.
    mag     = {1'b0, exp_t, man_t} + (MAG_W+1)'(round_up);
    rnd_ovf = mag[MAG_W] || (&mag[MAG_W-1:MAN_W]);

    if (s1_zero) begin
      res = {s1_sign, {MAG_W{1'b0}}};
    end else if (s1_ovf || rnd_ovf) begin
      res_oflow = 1'b1;
      if (SATURATE != 0) res = {s1_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      else               res = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      res       = {s1_sign, mag[MAG_W-1:0]};
      res_uflow = s1_sub && (guard || sticky);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      mac_out   <= '0;
      oflow     <= 1'b0;
      uflow     <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        mac_out <= res;
        oflow   <= res_oflow;
        uflow   <= res_uflow;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky exception flags: set on output handshake, clear has priority
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oflow_sticky <= 1'b0;
      uflow_sticky <= 1'b0;
    end else if (clr_flags) begin
      oflow_sticky <= 1'b0;
      uflow_sticky <= 1'b0;
    end else if (out_valid && out_ready) begin
      oflow_sticky <= oflow_sticky || oflow;
      uflow_sticky <= uflow_sticky || uflow;
    end
  end

endmodule

// File: tb/tb_mac_norm_pack_pipe.sv
// Directed bench for mac_norm_pack_pipe: vector table plus stall, sticky-clear and reset sequences.
// Expectations follow MAC_NORM_RNE_EN; a second instance checks SATURATE=1 results.
module tb_mac_norm_pack_pipe;

`ifdef MAC_NORM_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [12:0] norm_sum;
  logic [4:0]  signed_exp_diff;
  logic        exp_carry;
  logic        sign;
  logic [5:0]  max_exp;
  logic [4:0]  q_frac;
  logic        out_ready;
  logic        clr_flags;

  logic        in_ready,   in_ready_s;
  logic        out_valid,  out_valid_s;
  logic [15:0] mac_out,    mac_out_s;
  logic        oflow,      oflow_s;
  logic        uflow,      uflow_s;
  logic        oflow_sticky, oflow_sticky_s;
  logic        uflow_sticky, uflow_sticky_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mac_norm_pack_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .norm_sum(norm_sum), .signed_exp_diff(signed_exp_diff), .exp_carry(exp_carry),
    .sign(sign), .max_exp(max_exp), .q_frac(q_frac), .out_valid(out_valid),
    .out_ready(out_ready), .mac_out(mac_out), .oflow(oflow), .uflow(uflow),
    .clr_flags(clr_flags), .oflow_sticky(oflow_sticky), .uflow_sticky(uflow_sticky)
  );

  mac_norm_pack_pipe #(.SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .norm_sum(norm_sum), .signed_exp_diff(signed_exp_diff), .exp_carry(exp_carry),
    .sign(sign), .max_exp(max_exp), .q_frac(q_frac), .out_valid(out_valid_s),
    .out_ready(out_ready), .mac_out(mac_out_s), .oflow(oflow_s), .uflow(uflow_s),
    .clr_flags(clr_flags), .oflow_sticky(oflow_sticky_s), .uflow_sticky(uflow_sticky_s)
  );

  typedef struct {
    logic [5:0]  me;
    logic [4:0]  diff;
    logic        carry;
    logic        sgn;
    logic [4:0]  q;
    logic [12:0] sum;
    logic [15:0] out_t, out_r, sat_t, sat_r;
    logic        of_t, of_r, uf;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp_v);
    end
  endtask

  // Presents one beat and holds it until accepted; returns at accept edge + 1.
  task automatic drive(input vec_t v);
    bit hs;
    int n;
    max_exp = v.me; signed_exp_diff = v.diff; exp_carry = v.carry;
    sign = v.sgn; q_frac = v.q; norm_sum = v.sum; in_valid = 1'b1;
    n = 0;
    do begin
      hs = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < 20);
    in_valid = 1'b0;
    if (!hs) check("accept_timeout", 32'(hs), 32'd1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  function automatic vec_t mk(input logic [5:0] me, input logic [4:0] diff, input logic carry,
                              input logic sgn, input logic [4:0] q, input logic [12:0] sum,
                              input logic [15:0] out_t, input logic [15:0] out_r,
                              input logic [15:0] sat_t, input logic [15:0] sat_r,
                              input logic of_t, input logic of_r, input logic uf);
    vec_t v;
    v.me = me; v.diff = diff; v.carry = carry; v.sgn = sgn; v.q = q; v.sum = sum;
    v.out_t = out_t; v.out_r = out_r; v.sat_t = sat_t; v.sat_r = sat_r;
    v.of_t = of_t; v.of_r = of_r; v.uf = uf;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; norm_sum = '0; signed_exp_diff = '0; exp_carry = 1'b0;
    sign = 1'b0; max_exp = '0; q_frac = '0; out_ready = 1'b1; clr_flags = 1'b0;

    //          me  diff   c  s  q  sum       trunc     rne       sat_t     sat_r   of_t of_r uf
    vecs[0]  = mk(30, 5'h00, 0, 0, 0, 13'h1004, 16'h5401, 16'h5401, 16'h5401, 16'h5401, 0, 0, 0);
    vecs[1]  = mk( 9, 5'h1F, 0, 0, 0, 13'h1000, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 0, 0, 0);
    vecs[2]  = mk(30, 5'h00, 0, 1, 0, 13'h0000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 0, 0, 0);
    vecs[3]  = mk( 0, 5'h00, 0, 0, 1, 13'h1000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
    vecs[4]  = mk(63, 5'h0F, 1, 0, 0, 13'h1000, 16'h7C00, 16'h7C00, 16'h7BFF, 16'h7BFF, 1, 1, 0);
    vecs[5]  = mk(30, 5'h00, 0, 0, 0, 13'h1FFE, 16'h57FF, 16'h5800, 16'h57FF, 16'h5800, 0, 0, 0);
    vecs[6]  = mk(40, 5'h1D, 1, 1, 4, 13'h1557, 16'hE555, 16'hE556, 16'hE555, 16'hE556, 0, 0, 0);
    vecs[7]  = mk( 9, 5'h00, 0, 0, 0, 13'h1001, 16'h0200, 16'h0200, 16'h0200, 16'h0200, 0, 0, 1);
    vecs[8]  = mk( 9, 5'h00, 0, 0, 0, 13'h1FFF, 16'h03FF, 16'h0400, 16'h03FF, 16'h0400, 0, 0, 1);
    vecs[9]  = mk(39, 5'h00, 0, 0, 0, 13'h1FFE, 16'h7BFF, 16'h7C00, 16'h7BFF, 16'h7BFF, 0, 1, 0);
    vecs[10] = mk(39, 5'h00, 0, 0, 0, 13'h1000, 16'h7800, 16'h7800, 16'h7800, 16'h7800, 0, 0, 0);
    vecs[11] = mk(40, 5'h00, 0, 0, 0, 13'h1000, 16'h7C00, 16'h7C00, 16'h7BFF, 16'h7BFF, 1, 1, 0);
    vecs[12] = mk(10, 5'h00, 0, 0, 0, 13'h1000, 16'h0400, 16'h0400, 16'h0400, 16'h0400, 0, 0, 0);
    vecs[13] = mk(63, 5'h0F, 1, 0, 0, 13'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_in_ready_sat", 32'(in_ready_s), 32'd1);
    check("rst_mac_out", 32'(mac_out), 32'd0);
    check("rst_flags", {29'd0, oflow, uflow, oflow_sticky | uflow_sticky}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table of single beats at full readiness
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i]);
      wait_out(lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd1);
      check($sformatf("v%0d_valid_sat", i), 32'(out_valid_s), 32'd1);
      check($sformatf("v%0d_mac_out", i), 32'(mac_out), 32'(RNE ? vecs[i].out_r : vecs[i].out_t));
      check($sformatf("v%0d_mac_out_sat", i), 32'(mac_out_s), 32'(RNE ? vecs[i].sat_r : vecs[i].sat_t));
      check($sformatf("v%0d_oflow", i), 32'(oflow), 32'(RNE ? vecs[i].of_r : vecs[i].of_t));
      check($sformatf("v%0d_oflow_sat", i), 32'(oflow_s), 32'(RNE ? vecs[i].of_r : vecs[i].of_t));
      check($sformatf("v%0d_uflow", i), 32'(uflow), 32'(vecs[i].uf));
      @(posedge clk); #1;
    end

    // Sticky flags accumulated from the table, then cleared
    check("sticky_o", 32'(oflow_sticky), 32'd1);
    check("sticky_u", 32'(uflow_sticky), 32'd1);
    check("sticky_u_sat", 32'(uflow_sticky_s), 32'd1);
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    check("clr_o", 32'(oflow_sticky), 32'd0);
    check("clr_u", 32'(uflow_sticky), 32'd0);

    // clr_flags on the same edge as a flagged handshake wins
    out_ready = 1'b0;
    drive(vecs[3]);
    wait_out(lat);
    check("held_uflow", 32'(uflow), 32'd1);
    @(posedge clk); #1;
    check("held_sticky", 32'(uflow_sticky), 32'd0);
    out_ready = 1'b1;
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    check("clr_wins_u", 32'(uflow_sticky), 32'd0);
    check("clr_wins_consumed", 32'(out_valid), 32'd0);
    drive(vecs[3]);
    wait_out(lat);
    @(posedge clk); #1;
    check("set_after_clr_u", 32'(uflow_sticky), 32'd1);
    check("set_after_clr_o", 32'(oflow_sticky), 32'd0);

    // 8-beat stream under backpressure
    fork
      begin : producer
        for (int i = 0; i < 8; i++) begin
          bit hs;
          int n;
          max_exp = 6'd30; signed_exp_diff = '0; exp_carry = 1'b0; sign = 1'b0; q_frac = '0;
          norm_sum = {1'b1, 10'(i + 1), 2'b00};
          in_valid = 1'b1;
          n = 0;
          do begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk); #1;
            n++;
          end while (!hs && n < 200);
          if (!hs) check("bp_accept_timeout", 32'(hs), 32'd1);
        end
        in_valid = 1'b0;
      end
      begin : consumer
        int got_idx;
        got_idx = 0;
        for (int c = 0; c < 300 && got_idx < 8; c++) begin
          if (c == 0)      out_ready = 1'b1;
          else if (c <= 5) out_ready = 1'b0;
          else             out_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (c == 4) begin
            check("bp_in_ready_stall", 32'(in_ready), 32'd0);
            check("bp_valid_stall", 32'(out_valid), 32'd1);
          end
          if (out_valid) check($sformatf("bp_head%0d", got_idx), 32'(mac_out), 32'(16'h5400 | 16'(got_idx + 1)));
          if (out_valid && out_ready) got_idx++;
          @(posedge clk); #1;
        end
        check("bp_count", 32'(got_idx), 32'd8);
      end
    join
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_drained", 32'(out_valid), 32'd0);

    // Reset in the middle of buffered traffic
    out_ready = 1'b0;
    drive(vecs[0]);
    drive(vecs[5]);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_mac_out", 32'(mac_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check("no_ghost_beats", 32'(seen), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
